// File: rtl/adc_meas_pkg.sv
// Shared types and limits for the ADC measurement scheduler and the front-end config block.
// Gain selection lives here so the config block applies the same threshold rule.
package adc_meas_pkg;

  typedef enum logic [3:0] {
    IDLE, RANGE_START, RANGE_WAIT, RANGE_EVAL, SETTLE,
    MEAS_START, MEAS_WAIT, PUBLISH, FAULT
  } state_t;

  typedef logic [1:0] gain_t;

  localparam int unsigned TH_LOW_DEF   = 2**14;
  localparam int unsigned TH_HIGH_DEF  = 2**17 - 2**14;
  localparam int unsigned GAIN_MAX_DEF = 3;

  // Strict comparisons: landing exactly on a threshold keeps the gain.
  function automatic gain_t next_gain(input logic [31:0] mag, input gain_t g,
                                      input logic [31:0] lo, input logic [31:0] hi,
                                      input gain_t gmax);
    if (mag < lo && g < gmax) return g + 2'd1;
    if (mag > hi && g != 2'd0) return g - 2'd1;
    return g;
  endfunction

endpackage

// File: rtl/adc_sample_clkgen.sv
// Gated square-wave divider for ADC conversion clocks.
// Held low with its phase cleared whenever run is low, so the first rising edge is HALF_PERIOD after run.
module adc_sample_clkgen #(
  parameter int unsigned HALF_PERIOD = 312
)(
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sample
);

  localparam int unsigned CW = $clog2(HALF_PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt    <= '0;
      sample <= 1'b0;
    end else if (cnt == CW'(HALF_PERIOD - 1)) begin
      cnt    <= '0;
      sample <= ~sample;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_meas_sched.sv
// Sequences adc_read: range pass, gain pick, settle, full pass, then publishes results with gain tags.
// One shared counter times the start pulse, settle delay, watchdog and fault hold; it clears on every state change.
module adc_meas_sched
  import adc_meas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 18,
  parameter int unsigned SAMPLE_HALF_PERIOD = 312,
  parameter int unsigned START_PULSE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES     = 2**22,
  parameter int unsigned TH_LOW             = TH_LOW_DEF,
  parameter int unsigned TH_HIGH            = TH_HIGH_DEF,
  parameter int unsigned GAIN_MAX           = GAIN_MAX_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_status,
  output logic                  sample_adc,
  output logic                  start_cycle_conv,
  output logic                  read_diapason,
  input  logic                  complete,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [1:0]            gain_1,
  output logic [1:0]            gain_2,
  output logic [DATA_WIDTH-1:0] result_1,
  output logic [DATA_WIDTH-1:0] result_2,
  output logic [1:0]            result_gain_1,
  output logic [1:0]            result_gain_2,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  busy
);

  state_t                state, nxt;
  logic [31:0]           cnt;
  logic [DATA_WIDTH-1:0] rng_1, rng_2;
  gain_t                 gain_1_n, gain_2_n;
  logic                  start;

  assign busy             = (state != IDLE);
  assign start_cycle_conv = start;

  adc_sample_clkgen #(.HALF_PERIOD(SAMPLE_HALF_PERIOD)) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .run    (enable || busy),
    .sample (sample_adc)
  );

  assign gain_1_n = next_gain(32'(rng_1), gain_1, TH_LOW, TH_HIGH, gain_t'(GAIN_MAX));
  assign gain_2_n = next_gain(32'(rng_2), gain_2, TH_LOW, TH_HIGH, gain_t'(GAIN_MAX));

  always_comb begin
    nxt   = state;
    start = 1'b0;
    case (state)
      IDLE:        if (enable) nxt = RANGE_START;
      RANGE_START: begin
        start = 1'b1;
        if (cnt == 32'(START_PULSE_CYCLES - 1)) nxt = RANGE_WAIT;
      end
      RANGE_WAIT: begin
        if (complete)                               nxt = RANGE_EVAL;
        else if (cnt == 32'(TIMEOUT_CYCLES - 1))    nxt = FAULT;
      end
      RANGE_EVAL:  nxt = (gain_1_n != gain_1 || gain_2_n != gain_2) ? SETTLE : MEAS_START;
      SETTLE:      if (cnt == 32'(SETTLE_CYCLES - 1)) nxt = MEAS_START;
      MEAS_START: begin
        start = 1'b1;
        if (cnt == 32'(START_PULSE_CYCLES - 1)) nxt = MEAS_WAIT;
      end
      MEAS_WAIT: begin
        if (complete)                               nxt = PUBLISH;
        else if (cnt == 32'(TIMEOUT_CYCLES - 1))    nxt = FAULT;
      end
      // adc_read cannot be aborted, so enable is only sampled once a result is out.
      PUBLISH:     nxt = enable ? RANGE_START : IDLE;
      FAULT:       if (cnt == 32'(START_PULSE_CYCLES - 1)) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      read_diapason <= 1'b0;
      gain_1        <= '0;
      gain_2        <= '0;
      rng_1         <= '0;
      rng_2         <= '0;
      result_1      <= '0;
      result_2      <= '0;
      result_gain_1 <= '0;
      result_gain_2 <= '0;
      result_valid  <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 32'd0 : cnt + 32'd1;

      // Pass selector only moves as a start pulse begins, never mid-conversion.
      if (nxt == RANGE_START) read_diapason <= 1'b1;
      if (nxt == MEAS_START)  read_diapason <= 1'b0;

      if (state == RANGE_WAIT && complete) begin
        rng_1 <= data_in_1;
        rng_2 <= data_in_2;
      end

      if (state == RANGE_EVAL) begin
        gain_1 <= gain_1_n;
        gain_2 <= gain_2_n;
      end

      if (state == PUBLISH) begin
        result_1      <= data_in_1;
        result_2      <= data_in_2;
        result_gain_1 <= gain_1;
        result_gain_2 <= gain_2;
        result_valid  <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      if (state == PUBLISH && result_valid && !result_ready) overrun <= 1'b1;
      else if (clr_status)                                    overrun <= 1'b0;

      if (nxt == FAULT && state != FAULT) timeout <= 1'b1;
      else if (clr_status)                timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_meas_sched.sv
// Directed bench for adc_meas_sched with a fixed-value adc_read model.
// Inputs driven on negedge; the model responds #1 after posedge; outputs sampled on negedge.
module tb_adc_meas_sched;

  localparam int DW  = 18;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst, enable, clr_status, complete, result_ready;
  logic [DW-1:0] data_in_1, data_in_2;
  logic          sample_adc, start_cycle_conv, read_diapason;
  logic [1:0]    gain_1, gain_2, result_gain_1, result_gain_2;
  logic [DW-1:0] result_1, result_2;
  logic          result_valid, overrun, timeout, busy;

  logic [DW-1:0] rng1, rng2, full1, full2;
  logic          model_on;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  adc_meas_sched #(
    .SAMPLE_HALF_PERIOD (8),
    .TIMEOUT_CYCLES     (1000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .clr_status       (clr_status),
    .sample_adc       (sample_adc),
    .start_cycle_conv (start_cycle_conv),
    .read_diapason    (read_diapason),
    .complete         (complete),
    .data_in_1        (data_in_1),
    .data_in_2        (data_in_2),
    .gain_1           (gain_1),
    .gain_2           (gain_2),
    .result_1         (result_1),
    .result_2         (result_2),
    .result_gain_1    (result_gain_1),
    .result_gain_2    (result_gain_2),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .overrun          (overrun),
    .timeout          (timeout),
    .busy             (busy)
  );

  // adc_read model: completes LAT cycles after start falls, holds data afterwards.
  initial begin
    logic prev_start;
    int   lat;
    prev_start = 1'b0;
    lat        = -1;
    complete   = 1'b0;
    data_in_1  = '0;
    data_in_2  = '0;
    forever begin
      @(posedge clk);
      #1;
      complete = 1'b0;
      if (rst) lat = -1;
      else begin
        if (prev_start && !start_cycle_conv && model_on) lat = LAT;
        else if (lat > 0) lat--;
        if (lat == 0) begin
          complete  = 1'b1;
          data_in_1 = read_diapason ? rng1 : full1;
          data_in_2 = read_diapason ? rng2 : full2;
          lat       = -1;
        end
      end
      prev_start = start_cycle_conv;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return start_cycle_conv;
      1:       return complete;
      2:       return result_valid;
      3:       return timeout;
      4:       return sample_adc;
      default: return 1'bx;
    endcase
  endfunction

  localparam int S_START = 0, S_CMP = 1, S_TMO = 3, S_SMP = 4;

  task automatic wait_sig(input int s, input logic v, input int max, input string tag, output int n);
    n = 0;
    while (sig(s) !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    if (sig(s) !== v) chk(tag, 64'(sig(s)), 64'(v));
  endtask

  // One full measurement, entered before its range pass completes.
  task automatic measure(input string tag, input logic [DW-1:0] r1, r2, f1, f2,
                         input logic [1:0] g1, g2, input bit settle,
                         input bit prev_vld, input bit ovr, input bit consume);
    int n;
    rng1 = r1; rng2 = r2; full1 = f1; full2 = f2;
    wait_sig(S_CMP, 1'b1, 200, {tag, "_rng_cmp"}, n);
    wait_sig(S_START, 1'b1, 1200, {tag, "_meas_start"}, n);
    chk({tag, "_start_lat"}, 64'(n), settle ? 64'd1026 : 64'd2);
    chk({tag, "_gain_1"}, 64'(gain_1), 64'(g1));
    chk({tag, "_gain_2"}, 64'(gain_2), 64'(g2));
    chk({tag, "_diap0"}, 64'(read_diapason), 64'd0);
    wait_sig(S_CMP, 1'b1, 200, {tag, "_full_cmp"}, n);
    @(negedge clk);
    chk({tag, "_vld_early"}, 64'(result_valid), 64'(prev_vld));
    @(negedge clk);
    chk({tag, "_vld"}, 64'(result_valid), 64'd1);
    chk({tag, "_res"}, {result_1, result_2}, {f1, f2});
    chk({tag, "_rgain"}, {result_gain_1, result_gain_2}, {g1, g2});
    chk({tag, "_ovr"}, 64'(overrun), 64'(ovr));
    if (consume) begin
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, "_vld_drop"}, 64'(result_valid), 64'd0);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({sample_adc, start_cycle_conv, read_diapason, gain_1, gain_2, result_1, result_2,
                result_gain_1, result_gain_2, result_valid, overrun, timeout, busy});
  endfunction

  initial begin
    int n1, n2;
    rst = 1'b1; enable = 1'b0; clr_status = 1'b0; result_ready = 1'b0; model_on = 1'b1;
    rng1 = 18'h08000; rng2 = 18'h08000; full1 = 18'h12345; full2 = 18'h12345;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 64'd0);

    enable = 1'b1;
    wait_sig(S_START, 1'b1, 20, "first_start", n1);
    chk("first_start_lat", 64'(n1), 64'd1);
    chk("range_diap", 64'(read_diapason), 64'd1);
    chk("busy_on", 64'(busy), 64'd1);
    wait_sig(S_SMP, 1'b1, 20, "first_sample", n2);
    chk("sample_first_rise", 64'(n1 + n2), 64'd8);

    measure("m1",  18'h08000, 18'h08000, 18'h12345, 18'h12345, 2'd0, 2'd0, 0, 0, 0, 1);
    measure("m2",  18'h08000, 18'h00100, 18'h00AAA, 18'h00BBB, 2'd0, 2'd1, 1, 0, 0, 1);
    measure("m3",  18'h08000, 18'h00100, 18'h11111, 18'h22222, 2'd0, 2'd2, 1, 0, 0, 1);
    measure("m4",  18'h00100, 18'h3F000, 18'h3FFFF, 18'h00000, 2'd1, 2'd1, 1, 0, 0, 1);
    measure("m5",  18'h1C001, 18'h1C000, 18'h20000, 18'h10000, 2'd0, 2'd1, 1, 0, 0, 1);
    measure("m6",  18'h04000, 18'h08000, 18'h01234, 18'h04321, 2'd0, 2'd1, 0, 0, 0, 1);
    measure("m7",  18'h00000, 18'h08000, 18'h00007, 18'h00008, 2'd1, 2'd1, 1, 0, 0, 1);
    measure("m8",  18'h00000, 18'h08000, 18'h00017, 18'h00018, 2'd2, 2'd1, 1, 0, 0, 1);
    measure("m9",  18'h00000, 18'h08000, 18'h00027, 18'h00028, 2'd3, 2'd1, 1, 0, 0, 1);
    measure("m10", 18'h00000, 18'h08000, 18'h0A5A5, 18'h05A5A, 2'd3, 2'd1, 0, 0, 0, 0);
    measure("m11", 18'h08000, 18'h1C000, 18'h1ABCD, 18'h2DCBA, 2'd3, 2'd1, 0, 1, 1, 0);

    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("m11_vld_drop", 64'(result_valid), 64'd0);

    // Watchdog: the model stays silent for this range pass.
    model_on = 1'b0;
    wait_sig(S_START, 1'b0, 20, "to_start_fall", n1);
    chk("tmo_pre", 64'(timeout), 64'd0);
    wait_sig(S_TMO, 1'b1, 1100, "to_wait", n1);
    chk("tmo_cycles", 64'(n1), 64'd1000);
    wait_sig(S_START, 1'b1, 20, "to_restart", n1);
    chk("tmo_restart_lat", 64'(n1), 64'd5);
    model_on = 1'b1;
    chk("tmo_sticky", 64'(timeout), 64'd1);
    chk("tmo_gains_kept", 64'({gain_1, gain_2}), 64'({2'd3, 2'd1}));

    // Enable drops mid-measurement: result still published, then idle.
    rng1 = 18'h08000; rng2 = 18'h08000; full1 = 18'h0F0F0; full2 = 18'h0A0A0;
    wait_sig(S_CMP, 1'b1, 200, "m13_rng_cmp", n1);
    wait_sig(S_START, 1'b1, 50, "m13_meas_start", n1);
    chk("m13_start_lat", 64'(n1), 64'd2);
    wait_sig(S_START, 1'b0, 20, "m13_start_fall", n1);
    enable = 1'b0;
    wait_sig(S_CMP, 1'b1, 200, "m13_full_cmp", n1);
    repeat (2) @(negedge clk);
    chk("m13_vld", 64'(result_valid), 64'd1);
    chk("m13_res", {result_1, result_2}, {18'h0F0F0, 18'h0A0A0});
    chk("m13_idle", 64'(busy), 64'd0);
    @(negedge clk);
    chk("m13_sample_off", 64'(sample_adc), 64'd0);
    repeat (20) @(negedge clk);
    chk("m13_sample_held", 64'(sample_adc), 64'd0);
    chk("m13_no_restart", 64'({busy, start_cycle_conv}), 64'd0);

    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("tmo_cleared", 64'(timeout), 64'd0);

    // Reset in the middle of SETTLE.
    rng1 = 18'h3F000; rng2 = 18'h08000;
    enable = 1'b1;
    wait_sig(S_START, 1'b1, 20, "rs_start", n1);
    wait_sig(S_CMP, 1'b1, 200, "rs_rng_cmp", n1);
    repeat (10) @(negedge clk);
    chk("rs_gain_pre", 64'({gain_1, gain_2}), 64'({2'd2, 2'd1}));
    chk("rs_vld_pre", 64'(result_valid), 64'd1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("rs_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_idle", outs(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
